// File: rtl/serial_packet_transmit_pkg.sv
// Shared constants and types for the 88-byte work-packet serial protocol.
// Used by both the transmit and the receive side.
package serial_packet_transmit_pkg;

    localparam int unsigned PACKET_BYTES      = 88;
    localparam int unsigned PACKET_W          = PACKET_BYTES * 8;
    localparam int unsigned DATA_W            = 608;
    localparam int unsigned FIELD_W           = 32;
    localparam int unsigned DATA_MSB          = 703;
    localparam int unsigned NONCE_MSB         = 95;
    localparam int unsigned TARGET0_MSB       = 63;
    localparam int unsigned TARGET1_MSB       = 31;
    localparam int unsigned BYTE_CNT_W        = 7;
    localparam int unsigned DEF_GUARD_CYCLES  = 2;
    localparam int unsigned DEF_GAP_CYCLES    = 16;
    localparam int unsigned UART_CLKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GUARD,
        ST_READY,
        ST_GAP
    } tx_state_e;

    // Field order matches the on-wire byte order: data first, target1 last.
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [FIELD_W-1:0] nonce;
        logic [FIELD_W-1:0] target0;
        logic [FIELD_W-1:0] target1;
    } work_packet_t;

endpackage

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB-first bits. No reset: every counter runs down
// to idle on its own, so a byte in flight always completes.
module uart_transmitter
    import serial_packet_transmit_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rx_new_byte,
    input  logic [7:0] rx_byte,
    output logic       uart_tx,
    output logic       tx_ready
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT + 1);

    logic [9:0]        shifter, shifter_nxt;
    logic [3:0]        bits_left, bits_left_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_nxt;
    logic              line_low;

    // Frame is {stop, byte, start}; shifted out from bit 0.
    always_comb begin
        shifter_nxt   = shifter;
        bits_left_nxt = bits_left;
        baud_cnt_nxt  = baud_cnt;
        if (bits_left == 4'd0) begin
            if (rx_new_byte) begin
                shifter_nxt   = {1'b1, rx_byte, 1'b0};
                bits_left_nxt = 4'd10;
                baud_cnt_nxt  = '0;
            end
        end else if (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1)) begin
            baud_cnt_nxt  = '0;
            shifter_nxt   = {1'b1, shifter[9:1]};
            bits_left_nxt = bits_left - 4'd1;
        end else begin
            baud_cnt_nxt = baud_cnt + BAUD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        shifter   <= shifter_nxt;
        bits_left <= bits_left_nxt;
        baud_cnt  <= baud_cnt_nxt;
        line_low  <= (bits_left_nxt != 4'd0) && !shifter_nxt[0];
        tx_ready  <= (bits_left_nxt == 4'd0);
    end

    // Stored inverted so a zeroed register idles the line high.
    assign uart_tx = ~line_low;

endmodule

// File: rtl/serial_packet_transmit.sv
// Captures a 704-bit work packet on send and serializes it byte by byte,
// byte 0 = data[607:600] first, through uart_transmitter.
module serial_packet_transmit
    import serial_packet_transmit_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               send,
    input  logic [DATA_W-1:0]  data,
    input  logic [FIELD_W-1:0] nonce,
    input  logic [FIELD_W-1:0] target0,
    input  logic [FIELD_W-1:0] target1,
    output logic               TxD,
    output logic               busy,
    output logic               done
);

    localparam int unsigned WAIT_W = $clog2(GAP_CYCLES + GUARD_CYCLES + 1);

    tx_state_e               state;
    logic [PACKET_W-1:0]     capture;
    logic [BYTE_CNT_W-1:0]   byte_cnt;
    logic [WAIT_W-1:0]       wait_cnt;
    logic                    start;
    logic [7:0]              out_byte;
    logic                    tx_ready;
    work_packet_t            fields;

    assign fields = '{data: data, nonce: nonce, target0: target0, target1: target1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            start    <= 1'b0;
            byte_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            start <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A send coinciding with the done pulse is not taken.
                    if (send && !done) begin
                        capture  <= fields;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (tx_ready) begin
                        out_byte <= capture[DATA_MSB -: 8];
                        start    <= 1'b1;
                        capture  <= {capture[PACKET_W-9:0], 8'h00};
                        byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                        wait_cnt <= '0;
                        state    <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    // Gives the UART time to drop tx_ready after the start pulse.
                    if (wait_cnt == WAIT_W'(GUARD_CYCLES - 1)) begin
                        wait_cnt <= '0;
                        state    <= ST_READY;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_READY: begin
                    if (tx_ready) begin
                        wait_cnt <= '0;
                        state    <= (byte_cnt == BYTE_CNT_W'(PACKET_BYTES)) ? ST_GAP : ST_LOAD;
                    end
                end
                ST_GAP: begin
                    if (wait_cnt == WAIT_W'(GAP_CYCLES - 1)) begin
                        wait_cnt <= '0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_transmitter #(
        .CLKS_PER_BIT(UART_CLKS_PER_BIT)
    ) utx (
        .clk        (clk),
        .rx_new_byte(start),
        .rx_byte    (out_byte),
        .uart_tx    (TxD),
        .tx_ready   (tx_ready)
    );

endmodule

// File: tb/tb_serial_packet_transmit.sv
// Bench for serial_packet_transmit: decodes TxD as 8N1 and compares the byte
// stream against packets built from the fields.
module tb_serial_packet_transmit;
    import serial_packet_transmit_pkg::*;

    localparam int unsigned CPB     = UART_CLKS_PER_BIT;
    localparam int unsigned GAP     = DEF_GAP_CYCLES;
    localparam int          PKT_BUD = 8000;

    logic         clk = 1'b0;
    logic         reset;
    logic         send;
    logic [607:0] data;
    logic [31:0]  nonce, target0, target1;
    logic         TxD, busy, done;

    serial_packet_transmit dut (
        .clk    (clk),
        .reset  (reset),
        .send   (send),
        .data   (data),
        .nonce  (nonce),
        .target0(target0),
        .target1(target1),
        .TxD    (TxD),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    logic [7:0] rx_q[$];
    int         start_cyc[$];
    int         rx_started  = 0;
    int         framing_err = 0;
    bit         rx_en       = 0;

    typedef struct {
        logic [607:0] data;
        logic [31:0]  nonce, t0, t1;
        logic [7:0]   exp_b0, exp_b75;
        logic [31:0]  exp_mid, exp_t0b, exp_tail;
    } vec_t;

    vec_t tv[3];

    // Line receiver: sample mid-bit, LSB first, stop bit must be high.
    initial begin : uart_rx
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rx_en && TxD === 1'b0) begin
                rx_started++;
                start_cyc.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = TxD;
                end
                repeat (CPB) @(negedge clk);
                if (TxD !== 1'b1) framing_err++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] rxb(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'h00;
    endfunction

    // Byte k of a packet is the k-th byte counting from its MSB end.
    function automatic logic [7:0] model_byte(input logic [703:0] pkt, input int k);
        logic [703:0] s;
        s = pkt >> (8 * (87 - k));
        return s[7:0];
    endfunction

    function automatic logic [607:0] rand_data();
        logic [607:0] d;
        for (int w = 0; w < 19; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic clear_rx();
        rx_q.delete();
        start_cyc.delete();
        rx_started = 0;
    endtask

    task automatic apply_packet(input logic [607:0] d, input logic [31:0] n, t0, t1, input string name);
        @(negedge clk);
        data = d; nonce = n; target0 = t0; target1 = t1; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check(busy === 1'b1, {name, "_busy_after_send"}, busy, 1);
    endtask

    task automatic wait_done(input int budget, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1;
        end
        check(ok, {name, "_done_seen"}, ok, 1);
        check(busy === 1'b0, {name, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        check(done === 1'b0, {name, "_done_one_cycle"}, done, 0);
    endtask

    task automatic wait_started(input int n, input int budget, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (rx_started >= n) ok = 1;
        end
        check(ok, {name, "_reached_byte"}, rx_started, n);
    endtask

    task automatic idle_watch(input int n, output int dones);
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
    endtask

    task automatic check_packet(input logic [703:0] pkt, input int first, input int count, input string name);
        int bad, first_bad;
        bad = 0; first_bad = -1;
        for (int k = 0; k < count; k++) begin
            if (first + k >= rx_q.size() || rx_q[first + k] !== model_byte(pkt, k)) begin
                if (first_bad < 0) first_bad = k;
                bad++;
            end
        end
        if (bad != 0) $display("note %s: first differing byte index %0d", name, first_bad);
        check(bad == 0, {name, "_bytes_bad"}, bad, 0);
    endtask

    initial begin : main
        logic [703:0] pa, pb, pc;
        logic [607:0] d;
        logic [31:0]  n, t0, t1;
        int           dones, size_at_first, gap;

        tv[0].data = '0;           tv[0].nonce = 32'h11223344; tv[0].t0 = 32'h0;        tv[0].t1 = 32'hAABBCCDD;
        tv[0].exp_b0 = 8'h00;      tv[0].exp_b75 = 8'h00;
        tv[0].exp_mid = 32'h11223344; tv[0].exp_t0b = 32'h0; tv[0].exp_tail = 32'hAABBCCDD;

        tv[1].data = '0;           tv[1].data[607:600] = 8'hA5; tv[1].data[7:0] = 8'h3C;
        tv[1].nonce = 32'hDEADBEEF; tv[1].t0 = 32'h01234567;  tv[1].t1 = 32'h89ABCDEF;
        tv[1].exp_b0 = 8'hA5;      tv[1].exp_b75 = 8'h3C;
        tv[1].exp_mid = 32'hDEADBEEF; tv[1].exp_t0b = 32'h01234567; tv[1].exp_tail = 32'h89ABCDEF;

        tv[2].data = '1;           tv[2].nonce = 32'h0;        tv[2].t0 = 32'hFFFF0000; tv[2].t1 = 32'h00000001;
        tv[2].exp_b0 = 8'hFF;      tv[2].exp_b75 = 8'hFF;
        tv[2].exp_mid = 32'h0;     tv[2].exp_t0b = 32'hFFFF0000; tv[2].exp_tail = 32'h00000001;

        reset = 1'b1; send = 1'b0; data = '0; nonce = '0; target0 = '0; target1 = '0;
        repeat (100) @(negedge clk);
        check(busy === 1'b0, "reset_busy", busy, 0);
        check(done === 1'b0, "reset_done", done, 0);
        check(TxD === 1'b1, "reset_txd_idle", TxD, 1);
        reset = 1'b0;
        rx_en = 1'b1;
        repeat (5) @(negedge clk);

        // Directed vectors with hand-derived byte expectations.
        for (int v = 0; v < 3; v++) begin
            clear_rx();
            apply_packet(tv[v].data, tv[v].nonce, tv[v].t0, tv[v].t1, $sformatf("vec%0d", v));
            wait_done(PKT_BUD, $sformatf("vec%0d", v));
            check(rx_q.size() == 88, $sformatf("vec%0d_byte_count", v), rx_q.size(), 88);
            check(rxb(0) === tv[v].exp_b0, $sformatf("vec%0d_byte0", v), rxb(0), tv[v].exp_b0);
            check(rxb(75) === tv[v].exp_b75, $sformatf("vec%0d_byte75", v), rxb(75), tv[v].exp_b75);
            check({rxb(76), rxb(77), rxb(78), rxb(79)} === tv[v].exp_mid,
                  $sformatf("vec%0d_nonce_bytes", v), {rxb(76), rxb(77), rxb(78), rxb(79)}, tv[v].exp_mid);
            check({rxb(80), rxb(81), rxb(82), rxb(83)} === tv[v].exp_t0b,
                  $sformatf("vec%0d_target0_bytes", v), {rxb(80), rxb(81), rxb(82), rxb(83)}, tv[v].exp_t0b);
            check({rxb(84), rxb(85), rxb(86), rxb(87)} === tv[v].exp_tail,
                  $sformatf("vec%0d_target1_bytes", v), {rxb(84), rxb(85), rxb(86), rxb(87)}, tv[v].exp_tail);
            check_packet({tv[v].data, tv[v].nonce, tv[v].t0, tv[v].t1}, 0, 88, $sformatf("vec%0d", v));
        end

        // Random packets against the byte-order model.
        for (int r = 0; r < 3; r++) begin
            d = rand_data(); n = $urandom; t0 = $urandom; t1 = $urandom;
            clear_rx();
            apply_packet(d, n, t0, t1, $sformatf("rand%0d", r));
            wait_done(PKT_BUD, $sformatf("rand%0d", r));
            check(rx_q.size() == 88, $sformatf("rand%0d_byte_count", r), rx_q.size(), 88);
            check_packet({d, n, t0, t1}, 0, 88, $sformatf("rand%0d", r));
        end

        // Second send and field changes mid-packet must not disturb the first.
        d = rand_data(); n = $urandom; t0 = $urandom; t1 = $urandom;
        pa = {d, n, t0, t1};
        clear_rx();
        apply_packet(d, n, t0, t1, "midsend");
        wait_started(41, PKT_BUD, "midsend");
        @(negedge clk);
        data = ~d; nonce = ~n; target0 = ~t0; target1 = ~t1; send = 1'b1;
        repeat (5) @(negedge clk);
        send = 1'b0;
        wait_done(PKT_BUD, "midsend");
        idle_watch(300, dones);
        check(rx_q.size() == 88, "midsend_byte_count", rx_q.size(), 88);
        check(dones == 0, "midsend_no_extra_done", dones, 0);
        check_packet(pa, 0, 88, "midsend");

        // Reset during byte 50: that byte completes, nothing follows.
        d = rand_data(); n = $urandom; t0 = $urandom; t1 = $urandom;
        pb = {d, n, t0, t1};
        clear_rx();
        apply_packet(d, n, t0, t1, "rst");
        wait_started(51, PKT_BUD, "rst");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check(busy === 1'b0, "rst_busy_cleared", busy, 0);
        check(done === 1'b0, "rst_done_low", done, 0);
        idle_watch(400, dones);
        check(rx_q.size() == 51, "rst_bytes_sent", rx_q.size(), 51);
        check(dones == 0, "rst_no_done", dones, 0);
        check_packet(pb, 0, 51, "rst_partial");

        d = rand_data(); n = $urandom; t0 = $urandom; t1 = $urandom;
        pc = {d, n, t0, t1};
        clear_rx();
        apply_packet(d, n, t0, t1, "rst_after");
        wait_done(PKT_BUD, "rst_after");
        check(rx_q.size() == 88, "rst_after_byte_count", rx_q.size(), 88);
        check(rxb(0) === d[607:600], "rst_after_byte0", rxb(0), d[607:600]);
        check_packet(pc, 0, 88, "rst_after");

        // send held high: two packets separated by the gap and a done pulse.
        d = rand_data(); n = $urandom; t0 = $urandom; t1 = $urandom;
        pa = {d, n, t0, t1};
        clear_rx();
        dones = 0; size_at_first = -1;
        @(negedge clk);
        data = d; nonce = n; target0 = t0; target1 = t1; send = 1'b1;
        for (int i = 0; i < 2 * PKT_BUD && dones < 2; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) size_at_first = rx_q.size();
                if (dones == 2) send = 1'b0;
            end
        end
        send = 1'b0;
        check(dones == 2, "b2b_done_count", dones, 2);
        check(size_at_first == 88, "b2b_bytes_before_first_done", size_at_first, 88);
        idle_watch(300, dones);
        check(rx_q.size() == 176, "b2b_total_bytes", rx_q.size(), 176);
        check_packet(pa, 0, 88, "b2b_first");
        check_packet(pa, 88, 88, "b2b_second");
        gap = (start_cyc.size() > 88) ? (start_cyc[88] - start_cyc[87]) : 0;
        check(gap >= int'(10 * CPB + GAP + 1), "b2b_interpacket_gap", gap, 10 * CPB + GAP + 1);

        check(framing_err == 0, "framing_errors", framing_err, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
